gemm_result_streamer: RTL
=========================

# gemm_result_streamer

Drains the 32×48 result matrix from the tiled GEMM controller after each `done` pulse. It serializes `C_full` in row-major order onto a valid/ready stream, one element per beat. Each element is optionally requantized: arithmetic right shift, then saturation to `OUT_W`. It sits between `gemm_tiled_controller_3d` and the downstream consumer, and it holds `c_locked` so the controller does not overwrite `C_full` mid-drain.

## Interface
Reset is synchronous and active-high, on port `rst`. There is one clock, `clk`. All signed types come from `backbone_pkg`.

Parameters:
- `M_TOTAL`, 32, rows of C.
- `N_TOTAL`, 48, columns of C.
- `ACC_W`, `backbone_pkg::ACC_W`, width of each `C_full` element.
- `OUT_W`, `ACC_W`, width of `m_data`; must be ≤ `ACC_W`.
- `SHIFT`, 0, arithmetic right-shift amount; range 0..`ACC_W-1`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gemm_done`  in  1  one-cycle pulse from the controller: `C_full` is valid.
- `C_full`  in  signed [ACC_W-1:0] × [M_TOTAL][N_TOTAL]  result matrix.
- `c_locked`  out  1  high while a frame is streaming; the controller must not start a new GEMM or change `C_full`.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  consumer accepts the beat.
- `m_data`  out  signed [OUT_W-1:0]  requantized element.
- `m_row`  out  $clog2(M_TOTAL)  row index of the current beat.
- `m_col`  out  $clog2(N_TOTAL)  column index of the current beat.
- `m_row_last`  out  1  beat is column `N_TOTAL-1`.
- `m_last`  out  1  beat is element (`M_TOTAL-1`, `N_TOTAL-1`).
- `sat_count`  out  16  number of clamped elements in the current frame; saturates at 0xFFFF.
- `overrun`  out  1  sticky; set when `gemm_done` arrives mid-frame.

## Operation
- The FSM has two states: IDLE and STREAM.
- IDLE, `gemm_done`=1: load element (0,0) into the output register, set `m_valid`=1, clear `sat_count` (then count element (0,0) if it clamps), go to STREAM.
- STREAM, handshake (`m_valid && m_ready`), not `m_last`: advance `col`. On wrap at `N_TOTAL-1`, set `col`=0 and `row`+1. Load the next element into the output register.
- STREAM, handshake on `m_last`:
  - If `gemm_done`=1 in the same cycle, restart at (0,0) with `m_valid` held at 1, clear `sat_count`, and stay in STREAM.
  - Otherwise drive `m_valid`=0 and return to IDLE.
- STREAM, `gemm_done`=1 without a final handshake: the pulse is ignored and `overrun` is set. `overrun` clears only on `rst`.
- Requantization, computed when an element is loaded:
  - `t = C >>> SHIFT`, sign-extended at `ACC_W`.
  - If `t` > 2^(OUT_W-1)-1, emit the max and increment `sat_count`.
  - If `t` < -2^(OUT_W-1), emit the min and increment `sat_count`.
  - Otherwise emit `t[OUT_W-1:0]`.
  - With `OUT_W`=`ACC_W` and `SHIFT`=0 the output is a bit-exact pass-through and never saturates.
- `m_row_last` and `m_last` are registered alongside `m_data` and always describe the presented beat.
- `c_locked` = (state == STREAM).

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_row`=0, `m_col`=0, `m_row_last`=0, `m_last`=0, `c_locked`=0, `sat_count`=0, `overrun`=0; state IDLE.
- Latency: `gemm_done` sampled at edge T gives `m_valid`=1 with element (0,0) from just after T.
- Throughput: one beat per cycle while `m_ready`=1. A frame takes exactly `M_TOTAL·N_TOTAL` = 1536 handshakes.
- Stall rule: while `m_valid && !m_ready`, `m_data`, `m_row`, `m_col`, `m_row_last` and `m_last` are held stable. `m_valid` never drops without a handshake.
- `m_valid` does not depend combinationally on `m_ready`.
- `rst` mid-frame aborts the frame: all outputs return to reset values on the next edge, with no `m_last` beat.
- `C_full` is read combinationally at the current index when each element is loaded. Stability is guaranteed by the `c_locked` contract.

## Test plan
- Pass-through, C[i][j]=i·100+j, `m_ready`=1:
  - 1536 beats in order.
  - Beat 49 is (1,1) with value 101.
  - `m_row_last` is high on beats 47, 95, …
  - `m_last` is high only on (31,47) = 3147.
  - `c_locked` falls the cycle after the last handshake.
- Random `m_ready` (50% duty), random C:
  - Stream matches a row-major golden model.
  - Outputs stay stable during every stall cycle.
  - No beats are lost or duplicated.
- `OUT_W`=8, `SHIFT`=4, C(0,0)=1000, C(0,1)=5000, C(0,2)=-5000, C(0,3)=-16:
  - Beats are 62, 127, -128, -1.
  - `sat_count`=2 after the frame.
- `gemm_done` pulse at beat 500:
  - `overrun`=1 and stays 1.
  - The frame completes normally.
  - No restart occurs; `m_valid`=0 after `m_last`.
- `gemm_done` coincident with the final handshake:
  - `m_valid` stays 1.
  - The next beat is (0,0) of the new frame.
  - `sat_count` is cleared.
  - `overrun` stays 0.
- `rst` asserted at beat 700 with `m_ready`=0:
  - The next edge gives all outputs 0, state IDLE.
  - A subsequent `gemm_done` restarts cleanly at (0,0).

Source files
------------

// File: rtl/gemm_result_streamer.sv
// -----------------------------------------------------------------------------
// gemm_result_streamer
//
// Drains the M_TOTAL x N_TOTAL result matrix of the tiled GEMM controller after
// each gemm_done pulse. Elements go out in row-major order on a valid/ready
// stream, one element per beat. Each element is requantised on the way out:
// an arithmetic right shift by SHIFT, then saturation to OUT_W bits.
// c_locked is held for the whole frame so that the controller leaves C_full
// untouched while it is being read.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   gemm_done   in   one-cycle pulse: C_full holds a fresh result
//   C_full      in   signed [ACC_W-1:0] x [M_TOTAL][N_TOTAL] result matrix
//   c_locked    out  frame in flight; C_full must stay stable
//   m_valid     out  output beat valid
//   m_ready     in   consumer accepts the beat
//   m_data      out  signed [OUT_W-1:0] requantised element
//   m_row       out  row index of the presented beat
//   m_col       out  column index of the presented beat
//   m_row_last  out  presented beat is the last column of its row
//   m_last      out  presented beat is the last element of the frame
//   sat_count   out  clamped elements in the current frame (saturating, 16 bit)
//   overrun     out  sticky: gemm_done arrived while a frame was mid-stream
// -----------------------------------------------------------------------------

package backbone_pkg;
   parameter int unsigned ACC_W = 32;
   typedef logic signed [ACC_W-1:0] acc_t;
endpackage

module gemm_result_streamer #(
   parameter int unsigned M_TOTAL = 32,
   parameter int unsigned N_TOTAL = 48,
   parameter int unsigned ACC_W   = backbone_pkg::ACC_W,
   parameter int unsigned OUT_W   = ACC_W,
   parameter int unsigned SHIFT   = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            gemm_done,
   input  logic signed [ACC_W-1:0]         C_full [M_TOTAL][N_TOTAL],
   output logic                            c_locked,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic signed [OUT_W-1:0]         m_data,
   output logic [$clog2(M_TOTAL)-1:0]      m_row,
   output logic [$clog2(N_TOTAL)-1:0]      m_col,
   output logic                            m_row_last,
   output logic                            m_last,
   output logic [15:0]                     sat_count,
   output logic                            overrun
);

   localparam int unsigned ROW_W = $clog2(M_TOTAL);
   localparam int unsigned COL_W = $clog2(N_TOTAL);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M_TOTAL - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_TOTAL - 1);

   // Saturation bounds of an OUT_W-bit signed value, expressed at ACC_W so they
   // can be compared directly against the shifted accumulator.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e                   state_q, state_d;
   logic                     valid_q, valid_d;
   logic signed [OUT_W-1:0]  data_q, data_d;
   logic [ROW_W-1:0]         row_q, row_d;
   logic [COL_W-1:0]         col_q, col_d;
   logic                     row_last_q, row_last_d;
   logic                     last_q, last_d;
   logic [15:0]              sat_q, sat_d;
   logic                     overrun_q, overrun_d;

   // Load control: which element goes into the output register this cycle.
   logic                     handshake;
   logic                     load;
   logic                     frame_start;
   logic [ROW_W-1:0]         ld_row;
   logic [COL_W-1:0]         ld_col;

   // Requantisation datapath for the element being loaded.
   logic signed [ACC_W-1:0]  elem;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [OUT_W-1:0]  quant;
   logic                     clamp;

   assign handshake = valid_q && m_ready;

   // -------------------------------------------------------------------------
   // Next-state: FSM, index advance, requantisation and output register load.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      data_d      = data_q;
      row_d       = row_q;
      col_d       = col_q;
      row_last_d  = row_last_q;
      last_d      = last_q;
      sat_d       = sat_q;
      overrun_d   = overrun_q;

      load        = 1'b0;
      frame_start = 1'b0;
      ld_row      = row_q;
      ld_col      = col_q;

      unique case (state_q)
         StIdle: begin
            if (gemm_done) begin
               load        = 1'b1;
               frame_start = 1'b1;
               ld_row      = '0;
               ld_col      = '0;
               state_d     = StStream;
            end
         end

         StStream: begin
            if (handshake && last_q) begin
               if (gemm_done) begin
                  // Back-to-back frame: restart without a bubble.
                  load        = 1'b1;
                  frame_start = 1'b1;
                  ld_row      = '0;
                  ld_col      = '0;
               end else begin
                  valid_d = 1'b0;
                  state_d = StIdle;
               end
            end else begin
               // A done pulse that cannot start a new frame is dropped and flagged.
               if (gemm_done) begin
                  overrun_d = 1'b1;
               end
               if (handshake) begin
                  load = 1'b1;
                  if (col_q == COL_LAST) begin
                     ld_col = '0;
                     ld_row = row_q + 1'b1;
                  end else begin
                     ld_col = col_q + 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Element fetch at the index being loaded; only meaningful when load=1.
      elem    = C_full[ld_row][ld_col];
      shifted = elem >>> SHIFT;

      if (shifted > SAT_MAX) begin
         quant = SAT_MAX[OUT_W-1:0];
         clamp = 1'b1;
      end else if (shifted < SAT_MIN) begin
         quant = SAT_MIN[OUT_W-1:0];
         clamp = 1'b1;
      end else begin
         quant = shifted[OUT_W-1:0];
         clamp = 1'b0;
      end

      if (load) begin
         valid_d    = 1'b1;
         data_d     = quant;
         row_d      = ld_row;
         col_d      = ld_col;
         row_last_d = (ld_col == COL_LAST);
         last_d     = (ld_col == COL_LAST) && (ld_row == ROW_LAST);

         if (frame_start) begin
            sat_d = {15'd0, clamp};
         end else if (clamp && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         valid_q    <= 1'b0;
         data_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         row_last_q <= 1'b0;
         last_q     <= 1'b0;
         sat_q      <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         row_q      <= row_d;
         col_q      <= col_d;
         row_last_q <= row_last_d;
         last_q     <= last_d;
         sat_q      <= sat_d;
         overrun_q  <= overrun_d;
      end
   end

   assign c_locked   = (state_q == StStream);
   assign m_valid    = valid_q;
   assign m_data     = data_q;
   assign m_row      = row_q;
   assign m_col      = col_q;
   assign m_row_last = row_last_q;
   assign m_last     = last_q;
   assign sat_count  = sat_q;
   assign overrun    = overrun_q;

endmodule
